// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM encodings, parity modes, default bit timing and a parity helper.
// The transmitter and the UART receiver both import this package.
package uart_transmitter_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Callers zero-extend narrower words; the added zeros do not change the parity.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    logic result;
    result = 1'b0;
    if (mode == PARITY_EVEN) begin
      result = ^data;
    end else if (mode == PARITY_ODD) begin
      result = ~^data;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last and second-to-last cycle of each bit.
// Flags are registered, so they line up with the counter value they describe.
module uart_transmitter_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (clear || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      tick     <= 1'b0;
      pre_tick <= (PRE == '0);
    end else begin
      cnt      <= cnt_next;
      tick     <= (cnt_next == LAST);
      pre_tick <= (cnt_next == PRE);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s) on a registered tx line.
// Host handshake is send/ready; done pulses once per completed frame.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_idx_next;
  logic                 par;
  logic                 par_next;
  logic                 tx_next;
  logic                 ready_next;
  logic                 done_next;
  logic                 baud_clear;
  logic                 tick;
  logic                 pre_tick;

  uart_transmitter_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // tx/ready/done are computed for the next state so they change on the same edge as the FSM.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    par_next     = par;
    tx_next      = tx;
    ready_next   = 1'b0;
    done_next    = 1'b0;
    baud_clear   = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        baud_clear = 1'b1;
        if (send && ready) begin
          state_next   = ST_START;
          shreg_next   = data_in;
          par_next     = parity_bit(8'(data_in), PARITY);
          bit_idx_next = '0;
          tx_next      = 1'b0;
          ready_next   = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
          tx_next      = shreg[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_DATA) begin
            bit_idx_next = '0;
            if (PARITY != PARITY_NONE) begin
              state_next = ST_PARITY;
              tx_next    = par;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            shreg_next   = shreg >> 1;
            bit_idx_next = bit_idx + BIT_W'(1);
            tx_next      = shreg[1];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_next   = ST_STOP;
          bit_idx_next = '0;
          tx_next      = 1'b1;
        end
      end

      // The final stop cycle is spent in IDLE with ready high, so a held send starts the next
      // frame exactly when the stop time expires, with no gap on the line.
      ST_STOP: begin
        tx_next = 1'b1;
        if (pre_tick && (bit_idx == LAST_STOP)) begin
          state_next = ST_IDLE;
          ready_next = 1'b1;
          done_next  = 1'b1;
        end else if (tick) begin
          bit_idx_next = bit_idx + BIT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      par     <= par_next;
      tx      <= tx_next;
      ready   <= ready_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: three configurations, vector table, corner sequences and a
// loopback receiver model with a byte scoreboard.
module tb_uart_transmitter;

  localparam int CPB  = 10;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       send  [NDUT];
  logic       tx    [NDUT];
  logic       ready [NDUT];
  logic       done  [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic       rx_en = 1'b0;
  int         rx_count = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .data_in(data), .send(send[0]),
    .ready(ready[0]), .tx(tx[0]), .done(done[0]));

  uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data), .send(send[1]),
    .ready(ready[1]), .tx(tx[1]), .done(done[1]));

  uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .data_in(data), .send(send[2]),
    .ready(ready[2]), .tx(tx[2]), .done(done[2]));

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // dut0: no parity, 1 stop; dut1: even parity, 1 stop; dut2: odd parity, 2 stop.
  function automatic int frame_len(input int d);
    return CPB * (1 + 8 + ((d != 0) ? 1 : 0) + ((d == 2) ? 2 : 1));
  endfunction

  function automatic logic model_bit(input int d, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (d != 0 && idx == 9) return (d == 1) ? ^b : ~^b;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) send[i] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for ready, then presents data with send high; accept happens at the next posedge.
  task automatic start_frame(input int d, input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready[d] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", 32'(ready[d]), 32'(1));
    data    = b;
    send[d] = 1'b1;
  endtask

  // Consumes the accept edge and checks every cycle of the frame on tx, ready and done.
  task automatic check_frame(input int d, input logic [7:0] b, input bit keep_send,
                             input logic [7:0] next_data, output int len, output logic psample);
    int f;
    f       = frame_len(d);
    len     = 0;
    psample = 1'bx;
    @(posedge clk);
    for (int j = 0; j < f; j++) begin
      @(negedge clk);
      if (j == 0) begin
        data = next_data;
        if (!keep_send) send[d] = 1'b0;
      end
      if (!keep_send && j == 3 * CPB) send[d] = 1'b1;
      if (!keep_send && j == 3 * CPB + 1) send[d] = 1'b0;
      check($sformatf("tx d%0d b%02h c%0d", d, b, j), 32'(tx[d]), 32'(model_bit(d, b, j / CPB)));
      check($sformatf("ready d%0d c%0d", d, j), 32'(ready[d]), 32'(j == f - 1));
      check($sformatf("done d%0d c%0d", d, j), 32'(done[d]), 32'(j == f - 1));
      if (ready[d] && len == 0) len = j + 1;
      if (j == 9 * CPB + CPB / 2) psample = tx[d];
    end
  endtask

  // Loopback receiver on dut0: mid-bit sampling, checked against the scoreboard.
  task automatic rx_frame();
    logic [7:0] b;
    logic [7:0] exp;
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_bit", 32'(tx[0]), 32'(0));
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx[0];
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop_bit", 32'(tx[0]), 32'(1));
    if (sb.size() == 0) begin
      check("rx_unexpected_frame", 32'(1), 32'(0));
    end else begin
      exp = sb.pop_front();
      check("rx_byte", 32'(b), 32'(exp));
    end
    rx_count++;
  endtask

  initial begin : receiver
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_en && prev && !tx[0]) begin
        rx_frame();
        prev = 1'b1;
      end else begin
        prev = tx[0];
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         len;
    logic       ps;
    int         bad;
    int         w;
    logic [7:0] b;

    vecs[0] = '{0, 8'hA5, 1'b0, 100};
    vecs[1] = '{1, 8'h07, 1'b1, 110};
    vecs[2] = '{2, 8'h07, 1'b0, 120};
    vecs[3] = '{1, 8'hA5, 1'b0, 110};
    vecs[4] = '{2, 8'hA5, 1'b1, 120};
    vecs[5] = '{0, 8'h00, 1'b0, 100};
    vecs[6] = '{1, 8'hFF, 1'b0, 110};
    vecs[7] = '{2, 8'h80, 1'b0, 120};
    vecs[8] = '{0, 8'hFF, 1'b0, 100};
    vecs[9] = '{1, 8'h01, 1'b1, 110};

    reset = 1'b1;
    data  = 8'h00;
    for (int i = 0; i < NDUT; i++) send[i] = 1'b0;
    do_reset();

    // Reset state and a long idle stretch.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("idle_tx d%0d", d), 32'(tx[d]), 32'(1));
        check($sformatf("idle_ready d%0d", d), 32'(ready[d]), 32'(1));
        check($sformatf("idle_done d%0d", d), 32'(done[d]), 32'(0));
      end
    end

    // Vector table: waveform, measured frame length and parity bit.
    for (int v = 0; v < 10; v++) begin
      start_frame(vecs[v].dut, vecs[v].data);
      check_frame(vecs[v].dut, vecs[v].data, 1'b0, ~vecs[v].data, len, ps);
      check($sformatf("frame_len v%0d", v), 32'(len), 32'(vecs[v].exp_len));
      if (vecs[v].dut != 0) check($sformatf("parity v%0d", v), 32'(ps), 32'(vecs[v].exp_par));
    end

    // Back-to-back with send held: 55 then AA, no gap, then the line stays idle.
    start_frame(0, 8'h55);
    check_frame(0, 8'h55, 1'b1, 8'hAA, len, ps);
    check_frame(0, 8'hAA, 1'b0, 8'h3C, len, ps);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_b2b_tx", 32'(tx[0]), 32'(1));
      check("post_b2b_ready", 32'(ready[0]), 32'(1));
    end

    // Reset in the middle of data bit 3 aborts the frame.
    start_frame(0, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    send[0] = 1'b0;
    repeat (CPB * 4 + 3) @(negedge clk);
    check("bit3_before_reset", 32'(tx[0]), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx", 32'(tx[0]), 32'(1));
    check("abort_ready", 32'(ready[0]), 32'(1));
    check("abort_done", 32'(done[0]), 32'(0));
    bad = 0;
    for (int c = 0; c < frame_len(0); c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
    end
    check("abort_quiet_cycles", 32'(bad), 32'(0));
    start_frame(0, 8'hC3);
    check_frame(0, 8'hC3, 1'b0, 8'h00, len, ps);
    check("after_abort_len", 32'(len), 32'(100));

    // Reset and send together: reset wins and no frame starts.
    @(negedge clk);
    reset   = 1'b1;
    send[1] = 1'b1;
    data    = 8'h3C;
    @(negedge clk);
    reset   = 1'b0;
    send[1] = 1'b0;
    check("rst_send_ready", 32'(ready[1]), 32'(1));
    bad = 0;
    for (int c = 0; c < 3 * CPB; c++) begin
      @(negedge clk);
      if (tx[1] !== 1'b1 || ready[1] !== 1'b1) bad++;
    end
    check("rst_send_dropped", 32'(bad), 32'(0));

    // Loopback: 256 random bytes, send held high, data scrambled while busy.
    rx_en = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 256; n++) begin
      w = 0;
      while (!ready[0] && w < 300) begin
        data = 8'($urandom);
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        check("loop_ready_timeout", 32'(w), 32'(0));
        break;
      end
      b       = 8'($urandom);
      data    = b;
      send[0] = 1'b1;
      @(posedge clk);
      sb.push_back(b);
      @(negedge clk);
    end
    send[0] = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (2 * CPB) @(negedge clk);
    rx_en = 1'b0;
    check("loop_sb_empty", 32'(sb.size()), 32'(0));
    check("loop_rx_count", 32'(rx_count), 32'(256));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
